// File: rtl/imem_uart_loader.sv
// UART-driven debug loader: parses W/R byte commands, runs one SIB access
// (SETUP then ACCESS with timeout) and streams an ACK/NAK + read-data response.
module imem_uart_loader #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic [15:0] sib_addr,
  output logic [31:0] sib_wdata,
  output logic        sib_sel,
  output logic        sib_enable,
  output logic        sib_write,
  output logic [3:0]  sib_mask,
  input  logic [31:0] sib_rdata,
  input  logic        sib_ready,
  input  logic        sib_resp,
  output logic        busy
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {IDLE, ADDR_HI, ADDR_LO, DATA, SETUP, ACCESS, RESP} state_e;

  state_e        state_q, state_d;
  logic          write_q, write_d;
  logic [15:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    mask_q, mask_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  // Response bytes are sent LSB-first by shifting right on each handshake.
  logic [39:0]   resp_q, resp_d;
  logic [2:0]    resp_cnt_q, resp_cnt_d;

  logic rx_fire, tx_fire;

  assign rx_ready   = (state_q == IDLE) || (state_q == ADDR_HI) ||
                      (state_q == ADDR_LO) || (state_q == DATA);
  assign tx_valid   = (state_q == RESP);
  assign tx_data    = resp_q[7:0];
  assign sib_sel    = (state_q == SETUP) || (state_q == ACCESS);
  assign sib_enable = (state_q == ACCESS);
  assign sib_addr   = addr_q;
  assign sib_wdata  = wdata_q;
  assign sib_write  = write_q;
  assign sib_mask   = mask_q;
  assign busy       = (state_q != IDLE);
  assign rx_fire    = rx_valid && rx_ready;
  assign tx_fire    = tx_valid && tx_ready;

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    mask_d     = mask_q;
    byte_cnt_d = byte_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    resp_d     = resp_q;
    resp_cnt_d = resp_cnt_q;
    case (state_q)
      IDLE: if (rx_fire) begin
        if (rx_data == 8'h57 || rx_data == 8'h52) begin
          write_d = (rx_data == 8'h57);
          state_d = ADDR_HI;
        end else begin
          resp_d     = {32'h0, NAK};
          resp_cnt_d = 3'd1;
          state_d    = RESP;
        end
      end
      ADDR_HI: if (rx_fire) begin
        addr_d[15:8] = rx_data;
        state_d      = ADDR_LO;
      end
      ADDR_LO: if (rx_fire) begin
        addr_d[7:0] = rx_data;
        mask_d      = write_q ? 4'hF : 4'h0;
        byte_cnt_d  = 2'd0;
        state_d     = write_q ? DATA : SETUP;
      end
      DATA: if (rx_fire) begin
        wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_data;
        byte_cnt_d = byte_cnt_q + 2'd1;
        if (byte_cnt_q == 2'd3) state_d = SETUP;
      end
      SETUP: begin
        tmo_cnt_d = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A ready on the final allowed cycle still completes normally.
        if (sib_ready) begin
          if (sib_resp) begin
            resp_d     = {32'h0, NAK};
            resp_cnt_d = 3'd1;
          end else if (write_q) begin
            resp_d     = {32'h0, ACK};
            resp_cnt_d = 3'd1;
          end else begin
            resp_d     = {sib_rdata, ACK};
            resp_cnt_d = 3'd5;
          end
          state_d = RESP;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
          resp_d     = {32'h0, NAK};
          resp_cnt_d = 3'd1;
          state_d    = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      RESP: if (tx_fire) begin
        resp_d     = {8'h0, resp_q[39:8]};
        resp_cnt_d = resp_cnt_q - 3'd1;
        if (resp_cnt_q == 3'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      byte_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      resp_q     <= '0;
      resp_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mask_q     <= mask_d;
      byte_cnt_q <= byte_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      resp_q     <= resp_d;
      resp_cnt_q <= resp_cnt_d;
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Transaction-level bench: drives command bytes, models the SIB slave and
// the UART sink, and compares against an expected response per command.
module tb_imem_uart_loader;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h0;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b1;
  logic [15:0] sib_addr;
  logic [31:0] sib_wdata;
  logic        sib_sel, sib_enable, sib_write;
  logic [3:0]  sib_mask;
  logic [31:0] sib_rdata = 32'h0;
  logic        sib_ready = 1'b0;
  logic        sib_resp = 1'b0;
  logic        busy;

  imem_uart_loader #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .sib_addr(sib_addr), .sib_wdata(sib_wdata), .sib_sel(sib_sel),
    .sib_enable(sib_enable), .sib_write(sib_write), .sib_mask(sib_mask),
    .sib_rdata(sib_rdata), .sib_ready(sib_ready), .sib_resp(sib_resp),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // slave config and observations
  int          sib_wait = 0;       // wait cycles before ready; -1 = never
  logic        sib_resp_cfg = 1'b0;
  logic [31:0] rdata_cfg = 32'h0;
  int          en_cyc = 0;
  int          setup_cnt = 0;
  logic [15:0] cap_addr = 16'h0;
  logic [31:0] cap_wdata = 32'h0;
  logic [3:0]  cap_mask = 4'h0;
  logic        cap_write = 1'b0;
  logic [7:0]  got_q[$];
  int          tx_hold = 0;
  bit          tx_rnd = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h0;

  always @(negedge clk) begin
    if (sib_sel && sib_enable) begin
      en_cyc++;
      sib_ready = (sib_wait >= 0) && (en_cyc == sib_wait + 1);
      sib_resp  = sib_ready ? sib_resp_cfg : 1'($urandom);
      sib_rdata = sib_ready ? rdata_cfg : $urandom;
    end else begin
      // junk outside ACCESS must be ignored
      sib_ready = 1'($urandom);
      sib_resp  = 1'($urandom);
      sib_rdata = $urandom;
      if (sib_sel) begin
        setup_cnt++;
        cap_addr  = sib_addr;
        cap_wdata = sib_wdata;
        cap_mask  = sib_mask;
        cap_write = sib_write;
      end
    end
    if (prev_stall) begin
      chk("tx_hold_valid", tx_valid, 1'b1);
      chk("tx_hold_data", tx_data, prev_data);
    end
    if (tx_valid && tx_hold > 0) begin
      tx_ready = 1'b0;
      tx_hold--;
    end else begin
      tx_ready = tx_rnd ? 1'($urandom) : 1'b1;
    end
    prev_stall = tx_valid && !tx_ready;
    prev_data  = tx_data;
    if (tx_valid && tx_ready) got_q.push_back(tx_data);
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    while (!rx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) chk("rx_accept_timeout", rx_ready, 1'b1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] op, input logic [15:0] addr, input logic [31:0] wd,
                         input int wt, input logic rsp, input logic [31:0] rd,
                         input int hold, input bit rnd);
    logic [7:0] exp_q[$];
    int  exp_en, t, n;
    bit  valid_op, wr;
    valid_op = (op == 8'h57) || (op == 8'h52);
    wr       = (op == 8'h57);
    sib_wait = wt; sib_resp_cfg = rsp; rdata_cfg = rd;
    tx_hold = hold; tx_rnd = rnd;
    en_cyc = 0; setup_cnt = 0;
    got_q.delete();
    if (!valid_op) begin
      exp_q = '{8'h15}; exp_en = 0;
    end else if (wt < 0 || wt >= TMO) begin
      exp_q = '{8'h15}; exp_en = TMO;
    end else begin
      exp_en = wt + 1;
      if (rsp)     exp_q = '{8'h15};
      else if (wr) exp_q = '{8'h06};
      else         exp_q = '{8'h06, rd[7:0], rd[15:8], rd[23:16], rd[31:24]};
    end
    send_byte(op);
    if (valid_op) begin
      send_byte(addr[15:8]);
      send_byte(addr[7:0]);
      if (wr) for (int i = 0; i < 4; i++) send_byte(wd[8*i +: 8]);
    end
    t = 0;
    while ((got_q.size() < exp_q.size() || busy) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk("tx_len", got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk("tx_byte", got_q[i], exp_q[i]);
    chk("busy_end", busy, 1'b0);
    chk("setup_cycles", setup_cnt, valid_op ? 1 : 0);
    chk("enable_cycles", en_cyc, exp_en);
    if (valid_op) begin
      chk("sib_addr", cap_addr, addr);
      chk("sib_write", cap_write, wr);
      chk("sib_mask", cap_mask, wr ? 4'hF : 4'h0);
      if (wr) chk("sib_wdata", cap_wdata, wd);
    end
  endtask

  initial begin
    int t;
    logic [7:0] op;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sel", sib_sel, 1'b0);
    chk("rst_enable", sib_enable, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_addr", sib_addr, 16'h0);
    chk("rst_wdata", sib_wdata, 32'h0);
    chk("rst_mask", sib_mask, 4'h0);
    chk("rst_tx_data", tx_data, 8'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_rx_ready", rx_ready, 1'b1);

    run_txn(8'h57, 16'h0010, 32'hDEADBEEF, 0, 1'b0, 32'h0, 0, 1'b0);
    run_txn(8'h52, 16'h0100, 32'h0, 3, 1'b0, 32'h12345678, 0, 1'b0);
    run_txn(8'h41, 16'h0, 32'h0, 0, 1'b0, 32'h0, 0, 1'b0);
    run_txn(8'h52, 16'h0004, 32'h0, 0, 1'b0, 32'hA5C3_0F1E, 0, 1'b0);
    run_txn(8'h57, 16'h1234, 32'hCAFEF00D, -1, 1'b0, 32'h0, 0, 1'b0);
    run_txn(8'h57, 16'h00FF, 32'h01020304, TMO - 1, 1'b0, 32'h0, 0, 1'b0);
    run_txn(8'h52, 16'h0008, 32'h0, 2, 1'b1, 32'hAAAA5555, 5, 1'b0);

    // reset in the middle of an access
    sib_wait = -1; en_cyc = 0; got_q.delete();
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h20);
    for (int i = 0; i < 4; i++) send_byte(8'h11 * (i + 1));
    t = 0;
    while (!sib_enable && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("mid_reach_access", sib_enable, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_sel", sib_sel, 1'b0);
    chk("mid_rst_enable", sib_enable, 1'b0);
    chk("mid_rst_tx_valid", tx_valid, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_addr", sib_addr, 16'h0);
    chk("mid_rst_write", sib_write, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_rx_ready", rx_ready, 1'b1);
    chk("mid_rst_no_tx", got_q.size(), 0);
    run_txn(8'h57, 16'h0020, 32'h89ABCDEF, 1, 1'b0, 32'h0, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      op = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
      if ($urandom_range(0, 7) == 0) begin
        op = 8'($urandom);
        if (op == 8'h57 || op == 8'h52) op = 8'h41;
      end
      run_txn(op, 16'($urandom), $urandom, int'($urandom_range(0, 11)) - 1,
              ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)),
              bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1);
  end

endmodule
